// File: rtl/keypad_pkg.sv
//------------------------------------------------------------------------------
// keypad_pkg : shared types, column drive patterns and key decode map
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   localparam logic [3:0] COL_DRIVE_0 = 4'b1110;
   localparam logic [3:0] COL_DRIVE_1 = 4'b1101;
   localparam logic [3:0] COL_DRIVE_2 = 4'b1011;
   localparam logic [3:0] COL_DRIVE_3 = 4'b0111;

   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   function automatic logic [3:0] col_drive(input logic [1:0] ci);
      logic [3:0] drv;
      case (ci)
         2'd0:    drv = COL_DRIVE_0;
         2'd1:    drv = COL_DRIVE_1;
         2'd2:    drv = COL_DRIVE_2;
         default: drv = COL_DRIVE_3;
      endcase
      return drv;
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] ri, input logic [1:0] ci);
      logic [3:0] code;
      case ({ri, ci})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = KEY_STAR;
         4'b11_01: code = 4'h0;
         4'b11_10: code = KEY_HASH;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
//------------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for a bus of independent asynchronous bits
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
//------------------------------------------------------------------------------
// keypad_scan : 4x4 matrix keypad scanner with debounce, decode and digit buffer
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [3:0] c,
   output logic [3:0] d
);

   localparam int   TW     = $clog2(SCAN_DIV);
   localparam int   CW     = $clog2(DEBOUNCE + 1);
   localparam logic SINGLE = (DEBOUNCE == 1);

   logic [TW-1:0] timer;
   logic          sample;
   logic [3:0]    rs;
   state_t        state;
   logic [1:0]    ci;
   logic [1:0]    ri;
   logic [CW-1:0] cnt;
   logic [CW-1:0] rel;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] rel_inc;
   logic          low_any;
   logic [1:0]    low_row;
   logic          do_accept;
   logic          do_release;
   logic [3:0]    accept_code;

   sync_2ff #(
      .WIDTH     (4),
      .RESET_VAL (4'b1111)
   ) u_row_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_n),
      .q   (rs)
   );

   assign sample  = (timer == TW'(SCAN_DIV - 1));
   assign cnt_inc = cnt + CW'(1);
   assign rel_inc = rel + CW'(1);

   always_ff @(posedge clk) begin
      if (rst || sample) timer <= '0;
      else               timer <= timer + TW'(1);
   end

   // Lowest-numbered low row has priority.
   always_comb begin
      low_any = ~&rs;
      if      (!rs[0]) low_row = 2'd0;
      else if (!rs[1]) low_row = 2'd1;
      else if (!rs[2]) low_row = 2'd2;
      else             low_row = 2'd3;
   end

   always_comb begin
      do_accept   = 1'b0;
      do_release  = 1'b0;
      accept_code = key_map(ri, ci);
      if (sample) begin
         case (state)
            ST_SCAN: begin
               accept_code = key_map(low_row, ci);
               do_accept   = low_any && SINGLE;
            end
            ST_DEBOUNCE: do_accept  = !rs[ri] && (cnt_inc == CW'(DEBOUNCE));
            ST_HELD:     do_release = rs[ri] && (rel_inc == CW'(DEBOUNCE));
            default:     do_accept  = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_SCAN;
         ci    <= 2'd0;
         col_n <= COL_DRIVE_0;
         ri    <= 2'd0;
         cnt   <= '0;
         rel   <= '0;
      end else if (sample) begin
         case (state)
            ST_SCAN: begin
               if (low_any) begin
                  ri    <= low_row;
                  cnt   <= CW'(1);
                  rel   <= '0;
                  state <= SINGLE ? ST_HELD : ST_DEBOUNCE;
               end else begin
                  ci    <= ci + 2'd1;
                  col_n <= col_drive(ci + 2'd1);
               end
            end
            ST_DEBOUNCE: begin
               if (!rs[ri]) begin
                  cnt <= cnt_inc;
                  rel <= '0;
                  if (do_accept) state <= ST_HELD;
               end else begin
                  state <= ST_SCAN;
                  ci    <= ci + 2'd1;
                  col_n <= col_drive(ci + 2'd1);
               end
            end
            ST_HELD: begin
               if (!rs[ri]) begin
                  rel <= '0;
               end else if (do_release) begin
                  state <= ST_SCAN;
                  ci    <= ci + 2'd1;
                  col_n <= col_drive(ci + 2'd1);
               end else begin
                  rel <= rel_inc;
               end
            end
            default: state <= ST_SCAN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         a         <= 4'h0;
         b         <= 4'h0;
         c         <= 4'h0;
         d         <= 4'h0;
      end else begin
         key_valid <= do_accept;
         if (do_accept) begin
            key_code <= accept_code;
            key_held <= 1'b1;
            if (accept_code <= 4'd9) begin
               a <= b;
               b <= c;
               c <= d;
               d <= accept_code;
            end else if (accept_code == KEY_STAR) begin
               a <= 4'h0;
               b <= 4'h0;
               c <= 4'h0;
               d <= 4'h0;
            end
         end else if (do_release) begin
            key_held <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
//------------------------------------------------------------------------------
// tb_keypad_scan : randomized and directed keypad presses against a keypad model
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_keypad_scan;

   localparam int SD  = 4;
   localparam int DEB = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic [3:0] a, b, c, d;

   // pressed[r][c] = 1 when the switch at row r / column c is closed
   logic [3:0] pressed [4];

   int n_checks = 0;
   int n_fail   = 0;

   // reference state: phase 0 idle, 1 confirming, 2 held
   int m_phase, m_col, m_row, m_cnt, m_rel, m_timer, m_val, m_code;
   bit m_valid, m_held, last_samp;
   int km [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   always #5 clk = ~clk;

   always_comb begin
      for (int r = 0; r < 4; r++) row_n[r] = ~|(pressed[r] & ~col_n);
   end

   keypad_scan #(
      .SCAN_DIV (SD),
      .DEBOUNCE (DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_phase = 0; m_col = 0; m_row = 0; m_cnt = 0; m_rel = 0;
      m_timer = 0; m_val = 0; m_code = 0; m_valid = 0; m_held = 0;
   endfunction

   function automatic void model_accept();
      m_code  = km[m_row*4 + m_col];
      m_valid = 1;
      m_held  = 1;
      m_phase = 2;
      m_rel   = 0;
      if (m_code < 10)       m_val = (m_val * 10 + m_code) % 10000;
      else if (m_code == 14) m_val = 0;
   endfunction

   // One look at the keypad: which rows of the driven column read as closed.
   function automatic void model_sample();
      bit found = 0;
      case (m_phase)
         0: begin
            for (int r = 3; r >= 0; r--)
               if (pressed[r][m_col]) begin found = 1; m_row = r; end
            if (found) begin
               m_cnt = 1;
               if (m_cnt == DEB) model_accept(); else m_phase = 1;
            end else m_col = (m_col + 1) % 4;
         end
         1: begin
            if (pressed[m_row][m_col]) begin
               m_cnt++;
               if (m_cnt == DEB) model_accept();
            end else begin
               m_phase = 0;
               m_col   = (m_col + 1) % 4;
            end
         end
         default: begin
            if (!pressed[m_row][m_col]) begin
               m_rel++;
               if (m_rel == DEB) begin
                  m_phase = 0; m_held = 0;
                  m_col = (m_col + 1) % 4;
               end
            end else m_rel = 0;
         end
      endcase
   endfunction

   task automatic tick();
      bit samp;
      @(posedge clk);
      samp      = (m_timer == SD - 1);
      last_samp = 0;
      if (rst) model_reset();
      else begin
         m_valid = 0;
         m_timer = (m_timer + 1) % SD;
         if (samp) begin
            model_sample();
            last_samp = 1;
         end
      end
      #1;
      check("col_n",     32'(col_n),     32'(4'hF & ~(4'h1 << m_col)));
      check("key_valid", 32'(key_valid), 32'(m_valid));
      check("key_held",  32'(key_held),  32'(m_held));
      check("key_code",  32'(key_code),  32'(m_code));
      check("digits",    32'({a, b, c, d}),
            32'({4'(m_val / 1000), 4'((m_val / 100) % 10), 4'((m_val / 10) % 10), 4'(m_val % 10)}));
   endtask

   task automatic samples(input int n);
      int seen = 0;
      while (seen < n) begin
         tick();
         if (last_samp) seen++;
      end
   endtask

   task automatic release_all();
      for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
   endtask

   task automatic tap(input int r, input int col, input int hold);
      pressed[r][col] = 1'b1;
      samples(hold);
      release_all();
      samples(5);
   endtask

   initial begin
      rst = 1'b1;
      release_all();
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      samples(8);

      tap(1, 1, 10);                                        // "5"

      tap(0, 0, 8); tap(0, 1, 8); tap(0, 2, 8); tap(1, 0, 8); // 1 2 3 4
      tap(2, 2, 8);                                          // 9
      tap(3, 0, 8);                                          // *

      // bounce on key 1: one closed sample, one open, then stable
      for (int i = 0; i < 8 && !(m_col == 0 && m_phase == 0); i++) samples(1);
      pressed[0][0] = 1'b1; samples(1);
      release_all();        samples(1);
      tap(0, 0, 10);

      // A and C together on column 3, then 6 pressed while held
      pressed[0][3] = 1'b1;
      pressed[2][3] = 1'b1;
      samples(8);
      pressed[1][2] = 1'b1; samples(4);
      pressed[1][2] = 1'b0; samples(2);
      release_all();        samples(5);

      // reset while key 7 is being confirmed, key kept down afterwards
      pressed[2][0] = 1'b1;
      for (int i = 0; i < 8 && m_phase != 1; i++) samples(1);
      rst = 1'b1; tick(); rst = 1'b0;
      samples(12);
      release_all(); samples(5);

      for (int it = 0; it < 60; it++) begin
         release_all();
         for (int k = $urandom_range(0, 2); k > 0; k--)
            pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1; tick(); rst = 1'b0;
         end
         samples($urandom_range(1, 12));
      end
      release_all();
      samples(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
